// File: rtl/simon_round_sequencer.sv
// -----------------------------------------------------------------------------
// simon_round_sequencer
//   Round controller for the Simon Says core. Each round it appends one random
//   colour to the history array, plays the stored sequence oldest-first on the
//   LED driver, and then checks the player's presses against it in the same
//   order. Every output is registered.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   start        begin a new game (honoured in IDLE, FAIL, WIN)
//   rnd_colour   LFSR colour, captured as the game moves into ADD
//   segment      history array, segment[k] = k-th newest colour (slot 0 unused)
//   load_colour  one-cycle pulse: array shifts and captures new_colour
//   new_colour   colour presented with load_colour
//   seg_clear    one-cycle pulse on game start (clears the history array)
//   led_on       LED lit during playback
//   led_colour   colour shown while led_on, 0 otherwise
//   btn_valid    one-cycle pulse per debounced press
//   btn_colour   pressed colour, valid with btn_valid
//   level        current sequence length, 0..MAX_LEVEL
//   round_ok     one-cycle pulse when a round is fully matched
//   game_over    held high in FAIL
//   game_win     held high in WIN
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start after reset
// CLEAR    | history array cleared, level zeroed
// ADD      | one new colour shifted into the history array
// SETTLE   | array update becomes visible; playback index loaded
// SHOW_ON  | colour at idx lit for ON_CYCLES cycles
// SHOW_OFF | dark gap for OFF_CYCLES cycles, then next colour or INPUT
// INPUT    | presses compared against the sequence, idle timeout running
// FAIL     | wrong press or timeout; waits for start
// WIN      | MAX_LEVEL reached; waits for start
// -----------------------------------------------------------------------------
module simon_round_sequencer #(
  parameter int ON_CYCLES      = 4,
  parameter int OFF_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_LEVEL      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rnd_colour,
  input  logic [32:0][1:0] segment,
  output logic             load_colour,
  output logic [1:0]       new_colour,
  output logic             seg_clear,
  output logic             led_on,
  output logic [1:0]       led_colour,
  input  logic             btn_valid,
  input  logic [1:0]       btn_colour,
  output logic [5:0]       level,
  output logic             round_ok,
  output logic             game_over,
  output logic             game_win
);

  localparam int SHOW_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_MAX  = (SHOW_MAX > TIMEOUT_CYCLES) ? SHOW_MAX : TIMEOUT_CYCLES;
  localparam int TW       = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLEAR    = 4'd1;
  localparam logic [3:0] S_ADD      = 4'd2;
  localparam logic [3:0] S_SETTLE   = 4'd3;
  localparam logic [3:0] S_SHOW_ON  = 4'd4;
  localparam logic [3:0] S_SHOW_OFF = 4'd5;
  localparam logic [3:0] S_INPUT    = 4'd6;
  localparam logic [3:0] S_FAIL     = 4'd7;
  localparam logic [3:0] S_WIN      = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    level_q, level_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          round_ok_q, round_ok_d;
  logic [1:0]    new_colour_q;
  logic          load_colour_q, seg_clear_q, led_on_q, game_over_q, game_win_q;
  logic [1:0]    led_colour_q;

  // The timer counts down during playback (loaded with phase length - 1) and
  // counts up from zero in INPUT, where its value is the idle time so far.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    level_d    = level_q;
    tmr_d      = tmr_q;
    round_ok_d = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL, S_WIN: begin
        if (start) begin
          state_d = S_CLEAR;
          level_d = '0;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      S_CLEAR: state_d = S_ADD;
      S_ADD: begin
        level_d = level_q + 6'd1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        idx_d   = level_q;
        tmr_d   = TW'(ON_CYCLES - 1);
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tmr_q == '0) begin
          tmr_d   = TW'(OFF_CYCLES - 1);
          state_d = S_SHOW_OFF;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (idx_q == 6'd1) begin
          idx_d   = level_q;
          tmr_d   = '0;
          state_d = S_INPUT;
        end else begin
          idx_d   = idx_q - 6'd1;
          tmr_d   = TW'(ON_CYCLES - 1);
          state_d = S_SHOW_ON;
        end
      end
      S_INPUT: begin
        // A press always wins over a timeout landing on the same cycle.
        if (btn_valid) begin
          if (btn_colour != segment[idx_q]) begin
            state_d = S_FAIL;
          end else if (idx_q != 6'd1) begin
            idx_d = idx_q - 6'd1;
            tmr_d = '0;
          end else begin
            round_ok_d = 1'b1;
            state_d    = (level_q == 6'(MAX_LEVEL)) ? S_WIN : S_ADD;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_d == TW'(TIMEOUT_CYCLES)) state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      level_q       <= '0;
      tmr_q         <= '0;
      round_ok_q    <= 1'b0;
      new_colour_q  <= '0;
      load_colour_q <= 1'b0;
      seg_clear_q   <= 1'b0;
      led_on_q      <= 1'b0;
      led_colour_q  <= '0;
      game_over_q   <= 1'b0;
      game_win_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      level_q       <= level_d;
      tmr_q         <= tmr_d;
      round_ok_q    <= round_ok_d;
      load_colour_q <= (state_d == S_ADD);
      seg_clear_q   <= (state_d == S_CLEAR);
      led_on_q      <= (state_d == S_SHOW_ON);
      led_colour_q  <= (state_d == S_SHOW_ON) ? segment[idx_d] : 2'b00;
      game_over_q   <= (state_d == S_FAIL);
      game_win_q    <= (state_d == S_WIN);
      if (state_d == S_ADD) new_colour_q <= rnd_colour;
    end
  end

  assign load_colour = load_colour_q;
  assign new_colour  = new_colour_q;
  assign seg_clear   = seg_clear_q;
  assign led_on      = led_on_q;
  assign led_colour  = led_colour_q;
  assign level       = level_q;
  assign round_ok    = round_ok_q;
  assign game_over   = game_over_q;
  assign game_win    = game_win_q;

endmodule

// File: tb/tb_simon_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_round_sequencer
//   Directed bench: a cycle-by-cycle vector table for a full three-round game
//   ending in WIN and a restart, then hand-written sequences for a level-3
//   mismatch, the input timeout with restart, presses during playback, and
//   reset mid-playback. The history array is modelled in the bench.
// -----------------------------------------------------------------------------
module tb_simon_round_sequencer;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       rnd_colour;
  logic [32:0][1:0] hist;
  logic             load_colour;
  logic [1:0]       new_colour;
  logic             seg_clear;
  logic             led_on;
  logic [1:0]       led_colour;
  logic             btn_valid;
  logic [1:0]       btn_colour;
  logic [5:0]       level;
  logic             round_ok;
  logic             game_over;
  logic             game_win;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simon_round_sequencer #(
    .ON_CYCLES(2), .OFF_CYCLES(1), .TIMEOUT_CYCLES(8), .MAX_LEVEL(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rnd_colour(rnd_colour),
    .segment(hist), .load_colour(load_colour), .new_colour(new_colour),
    .seg_clear(seg_clear), .led_on(led_on), .led_colour(led_colour),
    .btn_valid(btn_valid), .btn_colour(btn_colour), .level(level),
    .round_ok(round_ok), .game_over(game_over), .game_win(game_win)
  );

  // History array: slot 1 newest, cleared by reset or seg_clear.
  always_ff @(posedge clk) begin
    if (reset || seg_clear) begin
      hist <= '0;
    end else if (load_colour) begin
      for (int k = 32; k >= 2; k--) hist[k] <= hist[k-1];
      hist[1] <= new_colour;
    end
  end

  typedef struct {
    logic       st;
    logic [1:0] rnd;
    logic       bv;
    logic [1:0] bc;
    logic       sc;
    logic       ld;
    logic [1:0] nc;
    logic       led;
    logic [1:0] lc;
    logic [5:0] lvl;
    logic       rok;
    logic       gov;
    logic       gwin;
  } vec_t;

  vec_t vecs[$];
  logic [1:0] seq [0:3];

  function automatic vec_t mk(input int st, rnd, bv, bc, sc, ld, nc, led, lc, lvl, rok, gov, gwin);
    vec_t v;
    v.st = 1'(st);  v.rnd = 2'(rnd); v.bv = 1'(bv);   v.bc = 2'(bc);
    v.sc = 1'(sc);  v.ld = 1'(ld);   v.nc = 2'(nc);   v.led = 1'(led);
    v.lc = 2'(lc);  v.lvl = 6'(lvl); v.rok = 1'(rok); v.gov = 1'(gov);
    v.gwin = 1'(gwin);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid  = 1'b1;
    btn_colour = c;
    tick(1);
    btn_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; btn_valid = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  // From IDLE/FAIL/WIN: start a game using seq[] and stop on the first cycle
  // of INPUT at level lvl. With noise set, btn_valid pulses during playback.
  task automatic goto_input(input int lvl, input bit noise);
    rnd_colour = seq[0];
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    for (int r = 1; r <= lvl; r++) begin
      for (int k = 0; k < r * 3 + 1; k++) begin
        btn_valid  = noise;
        btn_colour = 2'(k);
        tick(1);
      end
      btn_valid = 1'b0;
      if (r < lvl) begin
        rnd_colour = seq[r];
        for (int p = 0; p < r; p++) press(seq[p]);
        tick(1);
      end
    end
  endtask

  function automatic logic [15:0] outs_packed();
    return {seg_clear, load_colour, new_colour, led_on, led_colour, level,
            round_ok, game_over, game_win};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_v, act_v;
    reset = 1'b1; start = 1'b0; rnd_colour = 2'd0; btn_valid = 1'b0; btn_colour = 2'd0;
    tick(2);
    reset = 1'b0;
    chk("reset_outputs", 32'(outs_packed()), 32'd0);

    //          st rnd bv bc  sc ld nc led lc lvl rok gov win
    vecs.push_back(mk(1, 2, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // CLEAR
    vecs.push_back(mk(0, 2, 0, 0,  0, 1, 2, 0, 0, 0, 0, 0, 0)); // ADD
    vecs.push_back(mk(0, 2, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0)); // SETTLE
    vecs.push_back(mk(0, 2, 0, 0,  0, 0, 0, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 0,  0, 0, 0, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 2, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0)); // INPUT
    vecs.push_back(mk(0, 1, 1, 2,  0, 1, 1, 0, 0, 1, 1, 0, 0)); // match -> ADD
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 2, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 2, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0)); // INPUT
    vecs.push_back(mk(0, 1, 1, 2,  0, 0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 1,  0, 1, 3, 0, 0, 2, 1, 0, 0)); // -> ADD
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 2, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 2, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 3, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 1, 3, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0, 0, 3, 0, 0, 0)); // INPUT
    vecs.push_back(mk(0, 3, 1, 2,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 1,  0, 0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 3,  0, 0, 0, 0, 0, 3, 1, 0, 1)); // WIN
    vecs.push_back(mk(0, 3, 1, 0,  0, 0, 0, 0, 0, 3, 0, 0, 1)); // press ignored
    vecs.push_back(mk(1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0)); // start wins
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      start      = vecs[i].st;
      rnd_colour = vecs[i].rnd;
      btn_valid  = vecs[i].bv;
      btn_colour = vecs[i].bc;
      tick(1);
      exp_v = {vecs[i].sc, vecs[i].ld, vecs[i].nc, vecs[i].led, vecs[i].lc,
               vecs[i].lvl, vecs[i].rok, vecs[i].gov, vecs[i].gwin};
      act_v = outs_packed();
      if (vecs[i].ld == 1'b0) act_v[13:12] = vecs[i].nc;
      chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
    end
    start = 1'b0; btn_valid = 1'b0;

    // Level 3, sequence 0,3,1: the third press is wrong.
    do_reset();
    seq[0] = 2'd0; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd0;
    goto_input(3, 1'b0);
    chk("l3_level", 32'(level), 32'd3);
    press(2'd0);
    chk("l3_press1_over", 32'(game_over), 32'd0);
    press(2'd3);
    chk("l3_press2_over", 32'(game_over), 32'd0);
    press(2'd2);
    chk("l3_mismatch_over", 32'(game_over), 32'd1);
    chk("l3_mismatch_rok", 32'(round_ok), 32'd0);

    // Timeout: a press in idle cycle 7 restarts the count, then 8 idle cycles fail.
    seq[0] = 2'd1; seq[1] = 2'd2;
    goto_input(2, 1'b0);
    chk("to_restart_over", 32'(game_over), 32'd0);
    tick(7);
    chk("to_cycle7_over", 32'(game_over), 32'd0);
    press(2'd1);
    chk("to_press_at_expiry", 32'(game_over), 32'd0);
    tick(7);
    chk("to_7_idle", 32'(game_over), 32'd0);
    tick(1);
    chk("to_8_idle", 32'(game_over), 32'd1);

    // Presses during playback are ignored; INPUT starts at idx = level.
    seq[0] = 2'd3; seq[1] = 2'd0;
    goto_input(2, 1'b1);
    chk("noise_level", 32'(level), 32'd2);
    chk("noise_over", 32'(game_over), 32'd0);
    press(2'd3);
    chk("noise_press1_rok", 32'(round_ok), 32'd0);
    press(2'd0);
    chk("noise_press2_rok", 32'(round_ok), 32'd1);
    chk("noise_press2_load", 32'(load_colour), 32'd1);

    // Reset in the middle of level-3 playback.
    do_reset();
    seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd1;
    goto_input(2, 1'b0);
    rnd_colour = seq[2];
    press(seq[0]);
    press(seq[1]);
    tick(2);
    chk("mid_show_led", 32'({led_on, led_colour, level}), 32'({1'b1, 2'd2, 6'd3}));
    reset = 1'b1;
    tick(1);
    chk("mid_show_reset", 32'(outs_packed()), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("after_reset_idle", 32'(outs_packed()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_round_sequencer.md
# simon_round_sequencer

Round controller for the Simon Says core: it owns the colour-history shift array (33 × 2-bit, slot 1 = newest, slot 0 unused) and sequences each round. Each round it appends one random colour, plays the stored sequence oldest-first on the LED driver, then checks player button presses against it in the same order. It sits between the LFSR colour source, the segment array, the button debouncer and the top-level game FSM/display.

## Interface
- ON_CYCLES, 4: cycles each colour is lit during playback (≥1).
- OFF_CYCLES, 2: dark gap after each lit colour (≥1).
- TIMEOUT_CYCLES, 64: idle cycles allowed between presses in input phase (≥2).
- MAX_LEVEL, 32: sequence length that wins the game (1..32).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a new game; honoured only in IDLE, WIN or FAIL.
- rnd_colour  in  2  colour from the LFSR, sampled in ADD.
- segment  in  33×2  packed history array; segment[k] = k-th newest colour.
- load_colour  out  1  one-cycle pulse; array shifts and captures new_colour.
- new_colour  out  2  colour presented with load_colour.
- seg_clear  out  1  one-cycle pulse on game start; ORed into the array's reset at top level.
- led_on  out  1  LED lit.
- led_colour  out  2  colour shown when led_on; 0 otherwise.
- btn_valid  in  1  one-cycle pulse per debounced press.
- btn_colour  in  2  pressed colour, valid with btn_valid.
- level  out  6  current sequence length, 0..32.
- round_ok  out  1  one-cycle pulse when a round is fully matched.
- game_over  out  1  held high in FAIL.
- game_win  out  1  held high in WIN.

## Operation
- States: IDLE, CLEAR, ADD, SETTLE, SHOW_ON, SHOW_OFF, INPUT, FAIL, WIN.
- IDLE/FAIL/WIN + start → CLEAR. In CLEAR, seg_clear = 1 and level ← 0; next state is ADD.
- ADD: load_colour = 1, new_colour = rnd_colour, level ← level+1; next state is SETTLE.
- SETTLE: one cycle so the array update is visible; idx ← level; next state is SHOW_ON.
- SHOW_ON: led_on = 1, led_colour = segment[idx] for ON_CYCLES cycles; then SHOW_OFF.
- SHOW_OFF: dark for OFF_CYCLES cycles. If idx == 1: idx ← level, timer cleared, go to INPUT. Else idx ← idx−1, go to SHOW_ON.
- INPUT: on btn_valid, compare btn_colour with segment[idx].
  - Mismatch → FAIL.
  - Match with idx > 1 → idx ← idx−1 and timer cleared.
  - Match with idx == 1 → pulse round_ok. If level == MAX_LEVEL go to WIN, else go to ADD.
- INPUT timeout: timer increments each cycle without btn_valid. Reaching TIMEOUT_CYCLES → FAIL.
- btn_valid outside INPUT is ignored. start outside IDLE/FAIL/WIN is ignored.
- Index width is 6 bits; idx never reaches 0 and never exceeds level. Cycle counters are sized for max(ON, OFF, TIMEOUT).

## Timing
- Reset: state IDLE. All outputs 0: level = 0, led_on = 0, led_colour = 0, load_colour = 0, seg_clear = 0, round_ok = 0, game_over = 0, game_win = 0. Internal idx and timer are also 0.
- All outputs are registered. Reset has priority over every other input, including mid-playback and mid-input; the block returns to IDLE on the next edge.
- start sampled at edge t → seg_clear high in cycle t+1 → load_colour high in t+2 → SETTLE in t+3 → first led_on in t+4.
- Round of length L: playback lasts L·(ON_CYCLES+OFF_CYCLES) cycles, and INPUT is entered on the cycle after the last gap.
- A press sampled in INPUT takes effect at the next edge. On a final match, round_ok is high for exactly one cycle, in the same cycle the next ADD (or WIN) is entered.
- start and btn_valid high together in FAIL/WIN: start wins and btn_valid is ignored.
- btn_valid on the same cycle the timer expires: the press is evaluated and the timeout is ignored.

## Test plan
- Reset mid-SHOW_ON with level = 3 → next cycle IDLE, led_on = 0, level = 0, all flags 0.
- ON=2, OFF=1; start with rnd_colour = 2 then 1 → round 1 lights colour 2 for 2 cycles. Correct press 2 → round_ok. Round 2 plays 2 then 1; level = 2.
- Level 3 with sequence oldest→newest 0, 3, 1 → presses 0, 3, 2 → game_over asserts at the edge after the third press; no round_ok.
- TIMEOUT = 8 in INPUT with no press → FAIL after exactly 8 cycles. A press at cycle 7 restarts the count.
- MAX_LEVEL = 2 with all presses correct → game_win after the second round_ok. start then produces seg_clear and level returns to 1.
- btn_valid pulses during playback → ignored: idx and level unchanged, and INPUT starts with idx = level.
